cv32e40p_soc_sleep_ctrl: RTL and testbench

//  SoC-side consumer of the core's sleep indication (core_sleep_o). It qualifies sleep

---
 rtl/cv32e40p_soc_sleep_ctrl.sv | 122 ++++++++++++
 tb/tb_cv32e40p_soc_sleep_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_soc_sleep_ctrl.sv
// SoC sleep controller: qualifies core sleep, drives the core clock-gate
// enable, restores the clock on wake and counts gated cycles.
module cv32e40p_soc_sleep_ctrl #(
    parameter int ENTRY_DELAY = 4,
    parameter int WAKE_HOLD   = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk_ungated_i,
    input  logic             rst_n,
    input  logic             test_en_i,
    input  logic             gate_allow_i,
    input  logic             core_sleep_i,
    input  logic [31:0]      irq_i,
    input  logic             debug_req_i,
    input  logic             clr_cnt_i,
    output logic             core_clk_en_o,
    output logic             sleeping_o,
    output logic             wake_evt_o,
    output logic [CNT_W-1:0] sleep_cnt_o
);

    localparam int EW = (ENTRY_DELAY > 1) ? $clog2(ENTRY_DELAY) : 1;
    localparam int HW = (WAKE_HOLD > 1) ? $clog2(WAKE_HOLD) : 1;

    typedef enum logic [1:0] {
        RUN,
        ENTRY,
        GATED,
        WAKE
    } state_t;

    state_t         state_q, state_d;
    logic [EW-1:0]  ent_q, ent_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q;

    logic wake_src;
    logic exit_c;

    assign wake_src = (|irq_i) | debug_req_i;
    assign exit_c   = wake_src | ~core_sleep_i | ~gate_allow_i;

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ent_q   <= '0;
            hold_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            hold_q  <= hold_d;
            evt_q   <= evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        hold_d  = hold_q;
        evt_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!exit_c) begin
                    if (ENTRY_DELAY == 0) begin
                        state_d = GATED;
                    end else begin
                        state_d = ENTRY;
                        ent_d   = EW'(ENTRY_DELAY - 1);
                    end
                end
            end
            ENTRY: begin
                if (exit_c) begin
                    state_d = RUN;
                    ent_d   = '0;
                end else if (ent_q == '0) begin
                    state_d = GATED;
                end else begin
                    ent_d = ent_q - EW'(1);
                end
            end
            GATED: begin
                if (exit_c) begin
                    evt_d = 1'b1;
                    if (WAKE_HOLD == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAKE;
                        hold_d  = HW'(WAKE_HOLD - 1);
                    end
                end
            end
            WAKE: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Clear wins over increment; the count saturates at all-ones
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt_i) begin
            cnt_q <= '0;
        end else if (state_q == GATED && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign core_clk_en_o = (state_q != GATED) | test_en_i;
    assign sleeping_o    = (state_q == GATED);
    assign wake_evt_o    = evt_q;
    assign sleep_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cv32e40p_soc_sleep_ctrl.sv
// Bench for cv32e40p_soc_sleep_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_cv32e40p_soc_sleep_ctrl;

    localparam int D = 4;
    localparam int H = 2;

    logic        clk_ungated_i = 1'b0;
    logic        rst_n;
    logic        test_en_i, gate_allow_i, core_sleep_i;
    logic [31:0] irq_i;
    logic        debug_req_i, clr_cnt_i;

    logic        en_a, slp_a, evt_a;
    logic [31:0] cnt_a;
    logic        en_b, slp_b, evt_b;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    // Model: gated flag, entry age (-1 = idle), wake cycles left
    bit      m_gated;
    int      m_age;
    int      m_hold;
    bit      m_evt;
    longint  m_cnt32;
    int      m_cnt4;

    always #5 clk_ungated_i = ~clk_ungated_i;

    cv32e40p_soc_sleep_ctrl #(.ENTRY_DELAY(D), .WAKE_HOLD(H), .CNT_W(32)) u_dut (
        .clk_ungated_i (clk_ungated_i),
        .rst_n         (rst_n),
        .test_en_i     (test_en_i),
        .gate_allow_i  (gate_allow_i),
        .core_sleep_i  (core_sleep_i),
        .irq_i         (irq_i),
        .debug_req_i   (debug_req_i),
        .clr_cnt_i     (clr_cnt_i),
        .core_clk_en_o (en_a),
        .sleeping_o    (slp_a),
        .wake_evt_o    (evt_a),
        .sleep_cnt_o   (cnt_a)
    );

    cv32e40p_soc_sleep_ctrl #(.ENTRY_DELAY(D), .WAKE_HOLD(H), .CNT_W(4)) u_dut4 (
        .clk_ungated_i (clk_ungated_i),
        .rst_n         (rst_n),
        .test_en_i     (test_en_i),
        .gate_allow_i  (gate_allow_i),
        .core_sleep_i  (core_sleep_i),
        .irq_i         (irq_i),
        .debug_req_i   (debug_req_i),
        .clr_cnt_i     (clr_cnt_i),
        .core_clk_en_o (en_b),
        .sleeping_o    (slp_b),
        .wake_evt_o    (evt_b),
        .sleep_cnt_o   (cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gated = 0;
        m_age   = -1;
        m_hold  = 0;
        m_evt   = 0;
        m_cnt32 = 0;
        m_cnt4  = 0;
    endtask

    task automatic model_step();
        bit ex;
        ex = (irq_i != 0) || debug_req_i || !core_sleep_i || !gate_allow_i;
        m_evt = 0;
        if (clr_cnt_i) begin
            m_cnt32 = 0;
            m_cnt4  = 0;
        end else if (m_gated) begin
            if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_gated) begin
            if (ex) begin
                m_gated = 0;
                m_evt   = 1;
                m_hold  = H;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_age >= 0) begin
            if (ex) m_age = -1;
            else if (m_age == D - 1) begin
                m_age   = -1;
                m_gated = 1;
            end else m_age++;
        end else if (!ex) begin
            if (D == 0) m_gated = 1;
            else m_age = 0;
        end
    endtask

    task automatic check_all();
        logic exp_en;
        exp_en = !m_gated || test_en_i;
        chk("clk_en", {31'd0, en_a}, {31'd0, exp_en});
        chk("sleeping", {31'd0, slp_a}, {31'd0, m_gated});
        chk("wake_evt", {31'd0, evt_a}, {31'd0, m_evt});
        chk("cnt32", cnt_a, m_cnt32[31:0]);
        chk("clk_en4", {31'd0, en_b}, {31'd0, exp_en});
        chk("cnt4", {28'd0, cnt_b}, m_cnt4);
    endtask

    task automatic tick();
        @(posedge clk_ungated_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        test_en_i    = 1'b0;
        gate_allow_i = 1'b1;
        core_sleep_i = 1'b0;
        irq_i        = '0;
        debug_req_i  = 1'b0;
        clr_cnt_i    = 1'b0;
        model_reset();
        #23;
        check_all();
        chk("rst_en", {31'd0, en_a}, 32'd1);
        chk("rst_cnt", cnt_a, 32'd0);
        rst_n = 1'b1;

        // Entry: gated five cycles after sleep is first sampled
        core_sleep_i = 1'b1;
        ticks(4);
        chk("t1_en_c4", {31'd0, en_a}, 32'd1);
        tick();
        chk("t1_en_c5", {31'd0, en_a}, 32'd0);
        chk("t1_slp", {31'd0, slp_a}, 32'd1);
        ticks(9);
        irq_i[7] = 1'b1;
        tick();
        chk("t2_en", {31'd0, en_a}, 32'd1);
        chk("t2_evt", {31'd0, evt_a}, 32'd1);
        chk("t2_cnt", cnt_a, 32'd10);
        irq_i = '0;
        tick();
        chk("t2_evt_off", {31'd0, evt_a}, 32'd0);
        core_sleep_i = 1'b0;
        tick();
        chk("t2_run", {31'd0, slp_a}, 32'd0);

        // Abort during entry
        core_sleep_i = 1'b1;
        ticks(2);
        core_sleep_i = 1'b0;
        ticks(6);
        chk("t3_slp", {31'd0, slp_a}, 32'd0);
        chk("t3_cnt", cnt_a, 32'd10);

        // Policy blocks entry; losing permission wakes
        gate_allow_i = 1'b0;
        core_sleep_i = 1'b1;
        ticks(8);
        chk("t4_blocked", {31'd0, en_a}, 32'd1);
        gate_allow_i = 1'b1;
        ticks(8);
        gate_allow_i = 1'b0;
        tick();
        chk("t4_evt", {31'd0, evt_a}, 32'd1);
        gate_allow_i = 1'b1;
        core_sleep_i = 1'b0;
        ticks(3);

        // Saturation of narrow counter, then clear while counting
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        core_sleep_i = 1'b1;
        ticks(25);
        chk("t5_sat", {28'd0, cnt_b}, 32'd15);
        clr_cnt_i = 1'b1;
        tick();
        chk("t5_clr", cnt_a, 32'd0);
        clr_cnt_i = 1'b0;

        // Test mode forces the enable; reset mid-gated is immediate
        test_en_i = 1'b1;
        tick();
        chk("t6_test_en", {31'd0, en_a}, 32'd1);
        chk("t6_test_slp", {31'd0, slp_a}, 32'd1);
        test_en_i = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_en", {31'd0, en_a}, 32'd1);
        chk("t6_rst_slp", {31'd0, slp_a}, 32'd0);
        chk("t6_rst_cnt", cnt_a, 32'd0);
        #2;
        rst_n = 1'b1;
        core_sleep_i = 1'b0;
        tick();

        for (int i = 0; i < 4000; i++) begin
            core_sleep_i = ($urandom_range(0, 99) < 90);
            gate_allow_i = ($urandom_range(0, 99) < 95);
            irq_i        = ($urandom_range(0, 99) < 4) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            debug_req_i  = ($urandom_range(0, 99) < 2);
            clr_cnt_i    = ($urandom_range(0, 99) < 3);
            test_en_i    = ($urandom_range(0, 99) < 5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
